// File: rtl/axi4l_mult_slave.sv
`timescale 1ns/1ps
// AXI4-Lite peripheral around an SZ x SZ unsigned shift-add multiplier; product lands SZ cycles after start.
// One outstanding write and one outstanding read; a held B or R response stalls its address channel.
module axi4l_mult_slave #(
    parameter int SZ     = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              _rst,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              irq
);
    localparam int CW = $clog2(SZ + 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [ADDR_W-3:0] OFF_A      = (ADDR_W-2)'(0);
    localparam logic [ADDR_W-3:0] OFF_B      = (ADDR_W-2)'(1);
    localparam logic [ADDR_W-3:0] OFF_CTRL   = (ADDR_W-2)'(2);
    localparam logic [ADDR_W-3:0] OFF_STATUS = (ADDR_W-2)'(3);
    localparam logic [ADDR_W-3:0] OFF_RES_LO = (ADDR_W-2)'(4);
    localparam logic [ADDR_W-3:0] OFF_RES_HI = (ADDR_W-2)'(5);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [SZ-1:0]   a_q, a_d, b_q, b_d, mplier_q, mplier_d;
    logic [2*SZ-1:0] mcand_q, mcand_d, acc_q, acc_d, res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            irq_en_q, irq_en_d, done_q, done_d;
    logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]      bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [ADDR_W-3:0] wr_word, rd_word;
    logic              wr_fire, rd_fire, busy, start_req;
    logic [1:0]        wr_resp;
    logic [2*SZ-1:0]   acc_nxt;
    logic [63:0]       res_ext;
    logic              unused_addr_lsbs;

    function automatic logic [31:0] zext(input logic [SZ-1:0] v);
        logic [31:0] r;
        r = '0;
        r[SZ-1:0] = v;
        return r;
    endfunction

    function automatic logic [SZ-1:0] merge(input logic [SZ-1:0] old, input logic [31:0] data,
                                            input logic [3:0] strb);
        logic [31:0] r;
        r = zext(old);
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        return r[SZ-1:0];
    endfunction

    assign s_awready = s_awvalid & s_wvalid & ~bvalid_q;
    assign s_wready  = s_awready;
    assign s_arready = s_arvalid & ~rvalid_q;
    assign wr_fire   = s_awready;
    assign rd_fire   = s_arready;
    assign wr_word   = s_awaddr[ADDR_W-1:2];
    assign rd_word   = s_araddr[ADDR_W-1:2];
    assign busy      = (state_q == RUN);
    assign start_req = s_wdata[0] & s_wstrb[0];
    assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

    assign s_bvalid = bvalid_q;
    assign s_bresp  = bresp_q;
    assign s_rvalid = rvalid_q;
    assign s_rresp  = rresp_q;
    assign s_rdata  = rdata_q;
    assign irq      = done_q & irq_en_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        wr_resp  = RESP_OKAY;
        res_ext  = '0;
        acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);

        if (wr_fire) begin
            case (wr_word)
                OFF_A: if (busy) wr_resp = RESP_SLVERR; else a_d = merge(a_q, s_wdata, s_wstrb);
                OFF_B: if (busy) wr_resp = RESP_SLVERR; else b_d = merge(b_q, s_wdata, s_wstrb);
                OFF_CTRL: begin
                    if (busy && start_req) begin
                        wr_resp = RESP_SLVERR;
                    end else begin
                        if (s_wstrb[0]) irq_en_d = s_wdata[1];
                        if (start_req) begin
                            state_d  = RUN;
                            mcand_d  = {{SZ{1'b0}}, a_q};
                            mplier_d = b_q;
                            acc_d    = '0;
                            cnt_d    = CW'(SZ);
                            done_d   = 1'b0;
                        end
                    end
                end
                OFF_STATUS: if (s_wdata[1]) done_d = 1'b0; else wr_resp = RESP_DECERR;
                default: wr_resp = RESP_DECERR;
            endcase
        end

        // Completion is evaluated after the write decode so it overrides a same-cycle done clear.
        if (state_q == RUN) begin
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                res_d   = acc_nxt;
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        if (wr_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_resp;
        end else if (s_bready) begin
            bvalid_d = 1'b0;
        end

        // Read data is taken from next-state values so a read at a completion edge sees the result.
        res_ext[2*SZ-1:0] = res_d;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            case (rd_word)
                OFF_A:      rdata_d = zext(a_d);
                OFF_B:      rdata_d = zext(b_d);
                OFF_CTRL:   rdata_d = {30'b0, irq_en_d, 1'b0};
                OFF_STATUS: rdata_d = {30'b0, done_d, state_d == RUN};
                OFF_RES_LO: rdata_d = res_ext[31:0];
                OFF_RES_HI: rdata_d = res_ext[63:32];
                default: begin
                    rdata_d = '0;
                    rresp_d = RESP_DECERR;
                end
            endcase
        end else if (s_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            rvalid_q <= 1'b0;
            rresp_q  <= 2'b00;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule

// File: tb/tb_axi4l_mult_slave.sv
`timescale 1ns/1ps
// Directed bench for axi4l_mult_slave at SZ=32: reset, products, irq/W1C, busy and decode errors,
// response backpressure and reset during a run.
module tb_axi4l_mult_slave;
    localparam int SZ = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          _rst;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic          s_arvalid, s_arready, s_rvalid, s_rready, irq;
    logic [31:0]   s_wdata, s_rdata;
    logic [3:0]    s_wstrb;
    logic [1:0]    s_bresp, s_rresp;

    int          n_checks = 0;
    int          n_errors = 0;
    time         t_e, t_rise;
    logic        irq_wr;
    logic [31:0] rd;
    logic [1:0]  rr, br;

    always #5 clk = ~clk;

    axi4l_mult_slave #(.SZ(SZ), .ADDR_W(AW)) dut (
        .clk(clk), ._rst(_rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .irq(irq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        resp = 2'bxx;
        @(negedge clk);
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        #1;
        n = 0;
        while (!(s_awready && s_wready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) begin
            check("aw_timeout", 64'd0, 64'd1);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            return;
        end
        @(posedge clk);
        t_e = $time;
        #1 s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clk);
        irq_wr = irq;
        check("bvalid_next", s_bvalid, 1);
        if (!s_bvalid) return;
        resp = s_bresp;
        s_bready = 1'b1;
        @(posedge clk);
        #1 s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        data = 'x; resp = 2'bxx;
        @(negedge clk);
        s_araddr = addr; s_arvalid = 1'b1;
        #1;
        n = 0;
        while (!s_arready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) begin
            check("ar_timeout", 64'd0, 64'd1);
            s_arvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 s_arvalid = 1'b0;
        @(negedge clk);
        check("rvalid_next", s_rvalid, 1);
        if (!s_rvalid) return;
        data = s_rdata; resp = s_rresp;
        s_rready = 1'b1;
        @(posedge clk);
        #1 s_rready = 1'b0;
    endtask

    task automatic wait_irq();
        t_rise = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (irq) begin
                t_rise = $time;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        _rst = 1'b1;
        #2 _rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) _rst = 1'b1;
        @(negedge clk);
        check("rst_ctl_outs", {s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp, irq}, 0);
        check("rst_rdata", s_rdata, 0);
        axi_read(5'h0C, rd, rr); check("rst_status", rd, 0);
        axi_read(5'h10, rd, rr); check("rst_reslo", rd, 0); check("rst_reslo_resp", rr, 0);

        // Full-width product with irq enabled alongside start.
        axi_write(5'h00, 32'hFFFF_FFFF, 4'hF, br); check("full_a_resp", br, 0);
        axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, br); check("full_b_resp", br, 0);
        axi_write(5'h08, 32'h3, 4'h1, br);         check("full_start_resp", br, 0);
        axi_read(5'h0C, rd, rr); check("full_status_busy", rd, 32'h1);
        wait_irq();
        check("full_irq_lat", (t_rise - t_e - 5) / 10, SZ);
        axi_read(5'h0C, rd, rr); check("full_status_done", rd, 32'h2);
        axi_read(5'h10, rd, rr); check("full_res_lo", rd, 32'h0000_0001);
        axi_read(5'h14, rd, rr); check("full_res_hi", rd, 32'hFFFF_FFFE);
        axi_read(5'h08, rd, rr); check("ctrl_readback", rd, 32'h2);
        axi_write(5'h0C, 32'h2, 4'hF, br); check("w1c_resp", br, 0); check("w1c_irq_drop", irq_wr, 0);
        axi_read(5'h0C, rd, rr); check("w1c_status", rd, 32'h0);

        // Small product, irq and W1C.
        axi_write(5'h08, 32'h2, 4'h1, br);
        axi_write(5'h00, 32'h1234, 4'hF, br);
        axi_write(5'h04, 32'h0010, 4'hF, br);
        axi_write(5'h08, 32'h3, 4'h1, br);
        wait_irq();
        check("irq_lat", (t_rise - t_e - 5) / 10, SZ);
        axi_read(5'h10, rd, rr); check("irq_res_lo", rd, 32'h0001_2340);
        axi_read(5'h14, rd, rr); check("irq_res_hi", rd, 32'h0);
        axi_write(5'h0C, 32'h2, 4'hF, br); check("irq_w1c_drop", irq_wr, 0);

        // Busy protection with irq disabled.
        axi_write(5'h08, 32'h0, 4'h1, br); check("ctrl_off_resp", br, 0);
        axi_write(5'h00, 32'd7, 4'hF, br);
        axi_write(5'h04, 32'd9, 4'hF, br);
        axi_write(5'h08, 32'h1, 4'h1, br);
        axi_write(5'h00, 32'd5, 4'hF, br); check("busy_wr_a", br, 2'b10);
        axi_write(5'h08, 32'h1, 4'h1, br); check("busy_restart", br, 2'b10);
        for (int k = 0; k < 40; k++) begin
            axi_read(5'h0C, rd, rr);
            if (rd[1]) break;
        end
        check("busy_done", rd, 32'h2);
        axi_read(5'h10, rd, rr); check("busy_res", rd, 32'd63);
        axi_read(5'h00, rd, rr); check("busy_a_kept", rd, 32'd7);
        check("busy_no_irq", irq, 0);
        axi_write(5'h00, 32'hAABB_CCDD, 4'h5, br);
        axi_read(5'h00, rd, rr); check("wstrb_a", rd, 32'h00BB_00DD);

        // Decode errors.
        axi_write(5'h18, 32'h1, 4'hF, br); check("dec_wr_18", br, 2'b11);
        axi_read(5'h1C, rd, rr); check("dec_rd_1c_resp", rr, 2'b11); check("dec_rd_1c_data", rd, 0);
        axi_write(5'h10, 32'hDEAD, 4'hF, br); check("dec_wr_res", br, 2'b11);
        axi_read(5'h10, rd, rr); check("dec_res_kept", rd, 32'd63);

        // Response backpressure: B and R held for 5 cycles while new requests wait.
        @(negedge clk);
        s_awaddr = 5'h00; s_wdata = 32'h11; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
        #1 check("bp_aw_rdy", s_awready, 1);
        @(posedge clk); #1 s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clk);
        s_araddr = 5'h04; s_arvalid = 1'b1;
        #1 check("bp_ar_rdy", s_arready, 1);
        @(posedge clk); #1 s_arvalid = 1'b0;
        @(negedge clk);
        s_awaddr = 5'h04; s_wdata = 32'h22; s_awvalid = 1'b1; s_wvalid = 1'b1;
        s_araddr = 5'h00; s_arvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_bvalid", s_bvalid, 1);
            check("bp_bresp", s_bresp, 0);
            check("bp_awready", s_awready, 0);
            check("bp_rvalid", s_rvalid, 1);
            check("bp_rdata", s_rdata, 32'd9);
            check("bp_arready", s_arready, 0);
            @(negedge clk);
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        s_bready = 1'b1; s_rready = 1'b1;
        @(posedge clk); #1 s_bready = 1'b0; s_rready = 1'b0;
        axi_read(5'h00, rd, rr); check("bp_a_written", rd, 32'h11);
        axi_read(5'h04, rd, rr); check("bp_b_kept", rd, 32'd9);

        // Reset in the middle of a run.
        axi_write(5'h00, 32'd3, 4'hF, br);
        axi_write(5'h04, 32'd5, 4'hF, br);
        axi_write(5'h08, 32'h1, 4'h1, br);
        @(posedge clk);
        @(posedge clk);
        #1 _rst = 1'b0;
        @(negedge clk);
        check("rst_run_outs", {s_bvalid, s_rvalid, irq}, 0);
        repeat (2) @(negedge clk);
        _rst = 1'b1;
        axi_read(5'h0C, rd, rr); check("rst_run_status", rd, 0);
        axi_read(5'h10, rd, rr); check("rst_run_res", rd, 0);
        axi_read(5'h00, rd, rr); check("rst_run_a", rd, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
